// File: rtl/aap_decode_pkg.sv
// Shared definitions for the AAP fetch sequencer and the 16/32-bit decoder.
package aap_decode_pkg;

    // Occupancy of the fetch sequencer.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HAVE_LO = 2'd1,
        FULL    = 2'd2
    } seq_state_t;

    // Bit of the first fetched word that marks a 32-bit instruction.
    localparam int IS32_BIT = 15;

    // Default word-address width of fetch and decode PCs.
    localparam int DEFAULT_PC_WIDTH = 24;

    // A 32-bit instruction is presented as {hi, lo}; the decoder relies on this order.
    function automatic logic [31:0] pack_instr32(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/aap_fetch_sequencer.sv
// Assembles the 16-bit fetch stream into whole 16/32-bit AAP instructions and
// hands them to the decoder over a valid/ready handshake, with flush on redirect.
module aap_fetch_sequencer
    import aap_decode_pkg::*;
#(
    parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [15:0]          fetch_word,
    input  logic [PC_WIDTH-1:0]  fetch_pc,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [31:0]          dec_instr,
    output logic                 dec_is32,
    output logic [PC_WIDTH-1:0]  dec_pc,
    output logic                 seq_error,
    output logic [CNT_WIDTH-1:0] dec_count
);

    seq_state_t            state_reg;
    logic [15:0]           lo_word_reg;
    logic [PC_WIDTH-1:0]   lo_pc_reg;
    logic                  dec_valid_reg;
    logic [31:0]           dec_instr_reg;
    logic                  dec_is32_reg;
    logic [PC_WIDTH-1:0]   dec_pc_reg;
    logic                  seq_error_reg;
    logic [CNT_WIDTH-1:0]  dec_count_reg;

    logic                  accept;
    logic                  deliver;
    logic [PC_WIDTH-1:0]   lo_pc_inc;
    logic                  pair_done;
    logic                  pair_break;
    logic                  take_first;

    // The output slot can be refilled in the same cycle it is drained, so a
    // word is taken whenever the slot is free or the decoder is consuming it.
    assign fetch_ready = !reset && !flush && (state_reg != FULL || dec_ready);
    assign accept      = fetch_valid && fetch_ready;
    assign deliver     = dec_valid_reg && dec_ready;

    // Second half must sit at the next word address; the sum wraps at PC_WIDTH.
    assign lo_pc_inc  = lo_pc_reg + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign pair_done  = accept && (state_reg == HAVE_LO) && (fetch_pc == lo_pc_inc);
    assign pair_break = accept && (state_reg == HAVE_LO) && (fetch_pc != lo_pc_inc);
    // Any accepted word that does not complete a pair starts a new instruction.
    assign take_first = accept && !pair_done;

    // Sequencer FSM with registered decoder outputs and delivery counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= EMPTY;
            lo_word_reg   <= '0;
            lo_pc_reg     <= '0;
            dec_valid_reg <= 1'b0;
            dec_instr_reg <= '0;
            dec_is32_reg  <= 1'b0;
            dec_pc_reg    <= '0;
            seq_error_reg <= 1'b0;
            dec_count_reg <= '0;
        end else begin
            seq_error_reg <= pair_break;
            if (deliver) begin
                dec_count_reg <= dec_count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end

            if (flush) begin
                // A delivery in this cycle already counted above; anything else is dropped.
                state_reg     <= EMPTY;
                dec_valid_reg <= 1'b0;
            end else if (pair_done) begin
                state_reg     <= FULL;
                dec_valid_reg <= 1'b1;
                dec_instr_reg <= pack_instr32(fetch_word, lo_word_reg);
                dec_is32_reg  <= 1'b1;
                dec_pc_reg    <= lo_pc_reg;
            end else if (take_first) begin
                if (fetch_word[IS32_BIT]) begin
                    state_reg     <= HAVE_LO;
                    lo_word_reg   <= fetch_word;
                    lo_pc_reg     <= fetch_pc;
                    dec_valid_reg <= 1'b0;
                end else begin
                    state_reg     <= FULL;
                    dec_valid_reg <= 1'b1;
                    dec_instr_reg <= {16'h0000, fetch_word};
                    dec_is32_reg  <= 1'b0;
                    dec_pc_reg    <= fetch_pc;
                end
            end else if (deliver) begin
                state_reg     <= EMPTY;
                dec_valid_reg <= 1'b0;
            end
        end
    end

    assign dec_valid = dec_valid_reg;
    assign dec_instr = dec_instr_reg;
    assign dec_is32  = dec_is32_reg;
    assign dec_pc    = dec_pc_reg;
    assign seq_error = seq_error_reg;
    assign dec_count = dec_count_reg;

endmodule
